// File: rtl/ei_axi4_wdata_fifo.sv
// rtl/ei_axi4_wdata_fifo.sv - AXI4 W-channel FIFO with burst tracking and optional store-and-forward
// Optional: EI_AXI4_WLAST_CHK_EN adds a sticky wlast_err flag for bursts exceeding 256 beats.
module ei_axi4_wdata_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int STORE_FWD  = 0
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [DATA_WIDTH-1:0]        s_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s_wstrb,
  input  logic                         s_wlast,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic [DATA_WIDTH/8-1:0]      m_wstrb,
  output logic                         m_wlast,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   bursts
`ifdef EI_AXI4_WLAST_CHK_EN
  ,
  output logic                         wlast_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = DATA_WIDTH + DATA_WIDTH/8 + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d, bursts_q, bursts_d;
  logic          push, pop, full, not_empty;

  assign full      = (level_q == CW'(DEPTH));
  assign not_empty = (level_q != '0);
  assign s_wready  = aresetn && !full;
  // Full-release keeps over-long bursts moving when store-and-forward is on.
  assign m_wvalid  = aresetn && not_empty &&
                     ((STORE_FWD == 0) || (bursts_q != '0) || full);
  assign push      = s_wvalid && s_wready;
  assign pop       = m_wvalid && m_wready;

  assign {m_wlast, m_wstrb, m_wdata} = mem_q[rd_ptr_q];
  assign level  = level_q;
  assign bursts = bursts_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    bursts_d = bursts_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + CW'(1);
      2'b01:   level_d = level_q - CW'(1);
      default: level_d = level_q;
    endcase
    case ({push && s_wlast, pop && m_wlast})
      2'b10:   bursts_d = bursts_q + CW'(1);
      2'b01:   bursts_d = bursts_q - CW'(1);
      default: bursts_d = bursts_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      bursts_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      bursts_q <= bursts_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= {s_wlast, s_wstrb, s_wdata};
  end

`ifdef EI_AXI4_WLAST_CHK_EN
  logic [8:0] beat_cnt_q, beat_cnt_d;
  logic       wlast_err_q, wlast_err_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    wlast_err_d = wlast_err_q;
    if (push) begin
      if (s_wlast) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 9'd1;
        if (beat_cnt_q == 9'd255) wlast_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  assign wlast_err = wlast_err_q;
`endif

endmodule

// File: tb/tb_ei_axi4_wdata_fifo.sv
// tb/tb_ei_axi4_wdata_fifo.sv - directed bench for cut-through and store-and-forward W FIFOs
// Exercises the wlast_err checker when EI_AXI4_WLAST_CHK_EN is defined.
module tb_ei_axi4_wdata_fifo;

  logic        aclk = 1'b0;
  logic        aresetn;

  logic [31:0] a_s_wdata, a_m_wdata, b_s_wdata, b_m_wdata;
  logic [3:0]  a_s_wstrb, a_m_wstrb, b_s_wstrb, b_m_wstrb;
  logic        a_s_wlast, a_s_wvalid, a_s_wready, a_m_wlast, a_m_wvalid, a_m_wready;
  logic        b_s_wlast, b_s_wvalid, b_s_wready, b_m_wlast, b_m_wvalid, b_m_wready;
  logic [4:0]  a_level, a_bursts, b_level, b_bursts;
`ifdef EI_AXI4_WLAST_CHK_EN
  logic        a_wlast_err, b_wlast_err;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int tx, rx;
  logic seen, fire_s, fire_m;

  always #5 aclk = ~aclk;

  ei_axi4_wdata_fifo #(.DATA_WIDTH(32), .DEPTH(16), .STORE_FWD(0)) u_ct (
    .aclk(aclk), .aresetn(aresetn),
    .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wlast(a_s_wlast),
    .s_wvalid(a_s_wvalid), .s_wready(a_s_wready),
    .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb), .m_wlast(a_m_wlast),
    .m_wvalid(a_m_wvalid), .m_wready(a_m_wready),
    .level(a_level), .bursts(a_bursts)
`ifdef EI_AXI4_WLAST_CHK_EN
    , .wlast_err(a_wlast_err)
`endif
  );

  ei_axi4_wdata_fifo #(.DATA_WIDTH(32), .DEPTH(16), .STORE_FWD(1)) u_sf (
    .aclk(aclk), .aresetn(aresetn),
    .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wlast(b_s_wlast),
    .s_wvalid(b_s_wvalid), .s_wready(b_s_wready),
    .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb), .m_wlast(b_m_wlast),
    .m_wvalid(b_m_wvalid), .m_wready(b_m_wready),
    .level(b_level), .bursts(b_bursts)
`ifdef EI_AXI4_WLAST_CHK_EN
    , .wlast_err(b_wlast_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    a_s_wdata = '0; a_s_wstrb = 4'hF; a_s_wlast = 1'b0; a_s_wvalid = 1'b0; a_m_wready = 1'b0;
    b_s_wdata = '0; b_s_wstrb = 4'hF; b_s_wlast = 1'b0; b_s_wvalid = 1'b0; b_m_wready = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_inputs();
    repeat (2) step();
    aresetn = 1'b1;
  endtask

  initial begin
    clear_inputs();
    aresetn    = 1'b0;
    a_s_wvalid = 1'b1;
    b_s_wvalid = 1'b1;
    #1;
    repeat (3) step();
    chk("rst_a_sready", a_s_wready, 0);
    chk("rst_a_mvalid", a_m_wvalid, 0);
    chk("rst_a_level",  a_level, 0);
    chk("rst_a_bursts", a_bursts, 0);
    chk("rst_b_sready", b_s_wready, 0);
    chk("rst_b_mvalid", b_m_wvalid, 0);
    aresetn = 1'b1;
    a_s_wvalid = 1'b0;
    b_s_wvalid = 1'b0;
    step();
    chk("rel_a_sready", a_s_wready, 1);
    chk("rel_b_sready", b_s_wready, 1);
    chk("rel_a_level",  a_level, 0);

    // cut-through: each beat appears one cycle after its push
    a_m_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_s_wdata = 32'hA0 + i; a_s_wlast = (i == 3); a_s_wvalid = 1'b1;
      step();
      chk("ct_valid", a_m_wvalid, 1);
      chk("ct_data",  a_m_wdata, 32'hA0 + i);
      chk("ct_last",  a_m_wlast, (i == 3));
      chk("ct_level", a_level, 1);
    end
    chk("ct_bursts_1", a_bursts, 1);
    a_s_wvalid = 1'b0; a_s_wlast = 1'b0;
    step();
    chk("ct_level_0",  a_level, 0);
    chk("ct_bursts_0", a_bursts, 0);
    chk("ct_empty",    a_m_wvalid, 0);

    // fill to full, hold beat 17, single pop, then drain across the wrap
    a_m_wready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_s_wdata = 32'h100 + i; a_s_wlast = 1'b0; a_s_wvalid = 1'b1;
      step();
    end
    chk("full_level",  a_level, 16);
    chk("full_sready", a_s_wready, 0);
    a_s_wdata = 32'h110; a_s_wlast = 1'b1;
    step();
    chk("held_level",  a_level, 16);
    chk("held_sready", a_s_wready, 0);
    chk("held_head",   a_m_wdata, 32'h100);
    a_m_wready = 1'b1;
    step();
    a_m_wready = 1'b0;
    chk("pop1_level",  a_level, 15);
    chk("pop1_sready", a_s_wready, 1);
    chk("pop1_head",   a_m_wdata, 32'h101);
    step();
    a_s_wvalid = 1'b0; a_s_wlast = 1'b0;
    chk("b17_level",  a_level, 16);
    chk("b17_bursts", a_bursts, 1);
    a_m_wready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", a_m_wvalid, 1);
      chk("drain_data",  a_m_wdata, 32'h101 + i);
      chk("drain_last",  a_m_wlast, (i == 15));
      step();
    end
    chk("drain_level",  a_level, 0);
    chk("drain_bursts", a_bursts, 0);
    a_m_wready = 1'b0;

    // store-and-forward: output held until wlast is stored
    b_m_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_s_wdata = 32'hB0 + i; b_s_wlast = 1'b0; b_s_wvalid = 1'b1;
      step();
      chk("sf_hold", b_m_wvalid, 0);
    end
    b_s_wdata = 32'hB3; b_s_wlast = 1'b1;
    step();
    b_s_wvalid = 1'b0; b_s_wlast = 1'b0;
    chk("sf_release", b_m_wvalid, 1);
    chk("sf_bursts",  b_bursts, 1);
    chk("sf_level",   b_level, 4);
    for (int i = 0; i < 4; i++) begin
      chk("sf_data", b_m_wdata, 32'hB0 + i);
      chk("sf_last", b_m_wlast, (i == 3));
      step();
    end
    chk("sf_empty",    b_m_wvalid, 0);
    chk("sf_bursts_0", b_bursts, 0);

    // 20-beat burst through a 16-deep store-and-forward FIFO
    tx = 0; rx = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 200 && rx < 20; cyc++) begin
      b_s_wvalid = (tx < 20);
      b_s_wdata  = 32'hC0 + tx;
      b_s_wlast  = (tx == 19);
      if (b_m_wvalid && !seen) begin
        seen = 1'b1;
        chk("lb_rise_level", b_level, 16);
      end
      if (b_m_wvalid) begin
        chk("lb_data", b_m_wdata, 32'hC0 + rx);
        chk("lb_last", b_m_wlast, (rx == 19));
      end
      fire_s = b_s_wvalid && b_s_wready;
      fire_m = b_m_wvalid && b_m_wready;
      step();
      if (fire_s) tx++;
      if (fire_m) rx++;
    end
    b_s_wvalid = 1'b0; b_s_wlast = 1'b0;
    chk("lb_rx_count", rx, 20);
    chk("lb_level",    b_level, 0);
    chk("lb_bursts",   b_bursts, 0);

`ifdef EI_AXI4_WLAST_CHK_EN
    do_reset();
    a_m_wready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a_s_wdata = i; a_s_wlast = 1'b0; a_s_wvalid = 1'b1;
      step();
      if (i == 254) chk("werr_255", a_wlast_err, 0);
    end
    chk("werr_256", a_wlast_err, 1);
    a_s_wlast = 1'b1;
    step();
    a_s_wvalid = 1'b0; a_s_wlast = 1'b0;
    chk("werr_sticky", a_wlast_err, 1);
    do_reset();
    chk("werr_reset", a_wlast_err, 0);
    a_m_wready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a_s_wdata = i; a_s_wlast = (i == 255); a_s_wvalid = 1'b1;
      step();
    end
    a_s_wvalid = 1'b0; a_s_wlast = 1'b0;
    chk("werr_legal", a_wlast_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
